// File: rtl/uart_tx.sv
// uart_tx: FIFO-draining UART transmitter, 16x oversampled, with built-in baud divider
module uart_tx #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int BAUD_DIV = 163
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_r_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);
  localparam int DVW = $clog2(BAUD_DIV);
  localparam int SW  = $clog2(SB_TICK > 16 ? SB_TICK : 16);
  localparam int NW  = $clog2(DBIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state_q, state_d;
  logic [DVW-1:0]  div_q, div_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic            tx_q, tx_d;
  logic            tick;
  assign tick    = div_q == DVW'(BAUD_DIV - 1);
  assign tx      = tx_q;
  assign tx_busy = state_q != IDLE;
  // next-state, counters, pop request and done pulse; tx is precomputed from the next state so the line is a flop
  always_comb begin
    state_d      = state_q;
    div_d        = state_q == IDLE ? '0 : (tick ? '0 : div_q + 1'b1);
    s_d          = state_q == IDLE ? '0 : (tick ? s_q + 1'b1 : s_q);
    n_d          = state_q == IDLE ? '0 : n_q;
    sh_d         = sh_q;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
    case (state_q)
      IDLE: if (RESET && !fifo_empty) begin
        fifo_rd = 1'b1;
        sh_d    = fifo_r_data[DBIT-1:0];
        state_d = START;
      end
      START: if (tick && s_q == SW'(15)) begin
        s_d     = '0;
        state_d = DATA;
      end
      DATA: if (tick && s_q == SW'(15)) begin
        s_d     = '0;
        sh_d    = sh_q >> 1;
        n_d     = n_q == NW'(DBIT - 1) ? '0 : n_q + 1'b1;
        state_d = n_q == NW'(DBIT - 1) ? STOP : DATA;
      end
      STOP: if (tick && s_q == SW'(SB_TICK - 1)) begin
        s_d          = '0;
        tx_done_tick = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tx_d = state_d == START ? 1'b0 : (state_d == DATA ? sh_d[0] : 1'b1);
  end
  // state and datapath registers; reset drives the line high at once
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      div_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that drains the TX FIFO and serialises each byte onto the `tx` line as 8N1-style frames (start, DBIT data bits LSB first, configurable stop length). Sits directly downstream of the FIFO: it watches `empty`, pops one word with a single-cycle `rd` pulse, and shifts it out at 16× oversampled baud. A baud-tick divider is built in, so no external tick generator is needed.

## Interface
- DBIT, 8, data bits per frame (5..8); the low DBIT bits of `fifo_r_data` are sent.
- SB_TICK, 16, stop length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- BAUD_DIV, 163, clock cycles per oversample tick (≥2); one bit = 16·BAUD_DIV cycles.

- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO `empty` flag.
- fifo_r_data  in  8  FIFO head word; valid whenever `fifo_empty`=0; popped on the edge where `fifo_rd`=1.
- fifo_rd  out  1  pop request to the FIFO (`rd`), one cycle per frame.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  high from start bit through the last stop cycle.
- tx_done_tick  out  1  one-cycle pulse in the final cycle of each frame.

## Operation
- States: IDLE, START, DATA, STOP.
- Counters: `div_cnt` 0..BAUD_DIV-1 (tick when = BAUD_DIV-1, then wraps to 0); `s_cnt` 0..15 (or 0..SB_TICK-1 in STOP) counts ticks; `n_cnt` 0..DBIT-1 counts data bits; `sh` DBIT-bit shift register.
- IDLE: `tx`=1, all counters held at 0. `fifo_rd` = (state==IDLE) && !fifo_empty (combinational). On that edge: `sh` ← fifo_r_data[DBIT-1:0], go START.
- START: `tx`=0. After 16 ticks → DATA, `s_cnt`=0.
- DATA: `tx`=sh[0]. After 16 ticks: `sh` shifts right, `n_cnt`++; when `n_cnt` = DBIT-1 at the 16th tick → STOP.
- STOP: `tx`=1. On SB_TICK-th tick: `tx_done_tick`=1 that cycle, → IDLE.
- `tx_busy` = (state != IDLE).
- `fifo_rd` can never be asserted while `fifo_empty`=1, and never more than once per frame.
- `fifo_r_data` is ignored outside the IDLE→START edge; FIFO changes mid-frame have no effect.
- `tx` is registered (glitch-free).

## Timing
- Reset (RESET=0, asynchronous): state IDLE, `tx`=1, `tx_busy`=0, `fifo_rd`=0, `tx_done_tick`=0, all counters 0, `sh`=0.
- Reset mid-frame: line returns high immediately; the byte in flight is lost (already popped); no extra pop. After release, the next FIFO head is sent normally.
- Latency: `fifo_rd` high in cycle T (IDLE, non-empty); `tx` falls at edge T+1.
- Frame length from start-bit edge to the end of the `tx_done_tick` cycle: (16·(1+DBIT)+SB_TICK)·BAUD_DIV cycles.
- Back-to-back: if the FIFO is non-empty after a frame, there is exactly one IDLE cycle (high) between frames. Frame period = (16·(1+DBIT)+SB_TICK)·BAUD_DIV + 1 cycles.
- A FIFO write while `empty`=1 in IDLE: `fifo_rd` is asserted the cycle `empty` deasserts.
- The divider restarts at 0 on every IDLE→START transition, so bit edges are aligned to the start-bit edge.

## Test plan
Default bench parameters: BAUD_DIV=2, DBIT=8, SB_TICK=16, giving a 32-cycle bit and a 320-cycle frame.

- Reset values: hold RESET=0 with FIFO non-empty. Required: `tx`=1, `fifo_rd`=0, `tx_busy`=0, `tx_done_tick`=0. Release RESET: `fifo_rd` pulses once.
- Single byte 0x55: `tx` low for 32 cycles, then 1,0,1,0,1,0,1,0 at 32 cycles each, then high for 32 cycles. `tx_done_tick` is high exactly once, in cycle 320 after the start edge. `tx_busy` is high for 320 cycles.
- Back-to-back 0x01, 0x02, 0x03 preloaded: three `fifo_rd` pulses 321 cycles apart. Sampling at mid-bit decodes 0x01, 0x02, 0x03. After the third frame `fifo_empty`=1, and `tx` stays high with no further `fifo_rd`.
- Empty FIFO for 1000 cycles: `fifo_rd`=0 and `tx`=1 throughout. Then write 0xA5: `fifo_rd` is asserted in the first cycle `fifo_empty`=0, and 0xA5 is transmitted.
- Reset during data bit 3 of 0x0F, with 0x33 queued behind it: `tx`=1 and `tx_busy`=0 asynchronously. After release, 0x33 is sent in a full 320-cycle frame.
- SB_TICK=32: the stop interval is 64 cycles, the frame is 352 cycles, and the back-to-back period is 353 cycles.
